// File: rtl/d_counter_seq_checker_if.sv
// Bundle between a d_sync_counter observation point and its sequence checker.
//   master : drives q/qbar/sample_en/clr and receives the checker status
//   slave  : the checker side
// Signals:
//   q, qbar    W      counter output and its complement
//   sample_en  1      sample this cycle
//   clr        1      synchronous clear of err_cnt/wrap_cnt
//   locked     1      checker is locked onto the count sequence
//   err_pulse  1      one-cycle pulse per detected error
//   err_cnt    CNT_W  saturating error count
//   wrap_cnt   CNT_W  saturating wrap count (max -> 0 while locked)
//   last_q     W      last sampled q
interface d_counter_seq_checker_if #(
    parameter int W     = 4,
    parameter int CNT_W = 16
);
    logic [W-1:0]     q;
    logic [W-1:0]     qbar;
    logic             sample_en;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] wrap_cnt;
    logic [W-1:0]     last_q;

    modport master (
        output q, qbar, sample_en, clr,
        input  locked, err_pulse, err_cnt, wrap_cnt, last_q
    );

    modport slave (
        input  q, qbar, sample_en, clr,
        output locked, err_pulse, err_cnt, wrap_cnt, last_q
    );
endinterface

// File: rtl/d_counter_seq_checker.sv
// Downstream monitor for d_sync_counter. On every enabled edge it checks that
// q advanced by exactly +1 (mod 2^W) and that qbar == ~q. It locks after
// LOCK_CNT consecutive good increments, then flags/counts errors and wraps.
// Ports:
//   clk    rising-edge clock (same as the counter)
//   rst_n  asynchronous active-low reset
//   bus    d_counter_seq_checker_if.slave (inputs q/qbar/sample_en/clr,
//          registered outputs locked/err_pulse/err_cnt/wrap_cnt/last_q)
module d_counter_seq_checker #(
    parameter int W        = 4,
    parameter int LOCK_CNT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    d_counter_seq_checker_if.slave    bus
);

    localparam int GR_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [GR_W-1:0]  LOCK_V  = GR_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0]     Q_MAX   = '1;

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     prev_q, prev_d;
    logic [GR_W-1:0]  good_run_q, good_run_d;
    logic [W-1:0]     last_q_q, last_q_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    logic [W-1:0]     exp_q;
    logic [GR_W-1:0]  good_run_inc;
    logic             ok;
    logic             err_inc;
    logic             wrap_inc;

    // Expected value wraps naturally in W bits, so max -> 0 passes the check.
    assign exp_q        = prev_q + W'(1);
    assign ok           = (bus.q == exp_q) && (bus.qbar == ~bus.q);
    assign good_run_inc = good_run_q + GR_W'(1);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_run_d  = good_run_q;
        last_q_d    = last_q_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;
        wrap_inc    = 1'b0;

        if (bus.sample_en) begin
            // Every sample (good or bad) becomes the new reference.
            prev_d   = bus.q;
            last_q_d = bus.q;
            unique case (state_q)
                IDLE: begin
                    state_d    = SYNC;
                    good_run_d = '0;
                end
                SYNC: begin
                    if (ok) begin
                        if (good_run_inc == LOCK_V) begin
                            state_d    = LOCKED;
                            good_run_d = '0;
                        end else begin
                            good_run_d = good_run_inc;
                        end
                    end else begin
                        good_run_d = '0;
                    end
                end
                LOCKED: begin
                    if (ok) begin
                        wrap_inc = (prev_q == Q_MAX) && (bus.q == '0);
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        state_d     = SYNC;
                        good_run_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // clr dominates a same-cycle increment; counters never wrap.
        err_cnt_d = err_cnt_q;
        if (bus.clr)                                err_cnt_d = '0;
        else if (err_inc && err_cnt_q != CNT_MAX)   err_cnt_d = err_cnt_q + CNT_W'(1);

        wrap_cnt_d = wrap_cnt_q;
        if (bus.clr)                                wrap_cnt_d = '0;
        else if (wrap_inc && wrap_cnt_q != CNT_MAX) wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            good_run_q  <= '0;
            last_q_q    <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wrap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_run_q  <= good_run_d;
            last_q_q    <= last_q_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.wrap_cnt  = wrap_cnt_q;
    assign bus.last_q    = last_q_q;

endmodule

// File: tb/tb_d_counter_seq_checker.sv
// Bench for d_counter_seq_checker: two instances (CNT_W=16 and CNT_W=2) share
// the same stimulus; a streak-based reference model predicts all outputs.
module tb_d_counter_seq_checker;

    localparam int W    = 4;
    localparam int LOCK = 2;

    logic clk;
    logic rst_n;

    d_counter_seq_checker_if #(.W(W), .CNT_W(16)) bus_a ();
    d_counter_seq_checker_if #(.W(W), .CNT_W(2))  bus_b ();

    d_counter_seq_checker #(.W(W), .LOCK_CNT(LOCK), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    d_counter_seq_checker #(.W(W), .LOCK_CNT(LOCK), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: locked means "at least LOCK consecutive correct
    // increments since the last reference capture or failure".
    bit       m_have_prev;
    int       m_streak;
    int       m_prev;
    int       m_last;
    int       m_pulse;
    int       m_err_a, m_err_b, m_wrap_a, m_wrap_b;

    task automatic model_reset();
        m_have_prev = 0;
        m_streak    = 0;
        m_prev      = 0;
        m_last      = 0;
        m_pulse     = 0;
        m_err_a = 0; m_err_b = 0; m_wrap_a = 0; m_wrap_b = 0;
    endtask

    task automatic model_step(input int qv, input int qbv, input bit en, input bit c);
        bit is_ok, was_locked, e, wr;
        e = 0; wr = 0;
        m_pulse = 0;
        if (en) begin
            if (!m_have_prev) begin
                m_have_prev = 1;
                m_streak    = 0;
            end else begin
                was_locked = (m_streak >= LOCK);
                is_ok = (qv == (m_prev + 1) % 16) && (qbv == (15 - qv));
                if (is_ok) begin
                    if (was_locked && m_prev == 15 && qv == 0) wr = 1;
                    if (m_streak < LOCK) m_streak++;
                end else begin
                    if (was_locked) begin
                        e = 1;
                        m_pulse = 1;
                    end
                    m_streak = 0;
                end
            end
            m_prev = qv;
            m_last = qv;
        end
        if (c) begin
            m_err_a = 0; m_err_b = 0; m_wrap_a = 0; m_wrap_b = 0;
        end else begin
            if (e)  begin m_err_a  = (m_err_a  < 65535) ? m_err_a  + 1 : m_err_a;
                          m_err_b  = (m_err_b  < 3)     ? m_err_b  + 1 : m_err_b;  end
            if (wr) begin m_wrap_a = (m_wrap_a < 65535) ? m_wrap_a + 1 : m_wrap_a;
                          m_wrap_b = (m_wrap_b < 3)     ? m_wrap_b + 1 : m_wrap_b; end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"},    32'(bus_a.locked),    32'(m_have_prev && m_streak >= LOCK));
        chk({tag, ".err_pulse"}, 32'(bus_a.err_pulse), 32'(m_pulse));
        chk({tag, ".err_cnt"},   32'(bus_a.err_cnt),   32'(m_err_a));
        chk({tag, ".wrap_cnt"},  32'(bus_a.wrap_cnt),  32'(m_wrap_a));
        chk({tag, ".last_q"},    32'(bus_a.last_q),    32'(m_last));
        chk({tag, ".b_locked"},  32'(bus_b.locked),    32'(m_have_prev && m_streak >= LOCK));
        chk({tag, ".b_err_cnt"}, 32'(bus_b.err_cnt),   32'(m_err_b));
        chk({tag, ".b_wrap"},    32'(bus_b.wrap_cnt),  32'(m_wrap_b));
    endtask

    task automatic drive(input int qv, input int qbv, input bit en, input bit c);
        bus_a.q = 4'(qv); bus_a.qbar = 4'(qbv); bus_a.sample_en = en; bus_a.clr = c;
        bus_b.q = 4'(qv); bus_b.qbar = 4'(qbv); bus_b.sample_en = en; bus_b.clr = c;
    endtask

    // One clocked step: drive away from the edge, clock, model, compare at +1.
    task automatic step_qb(input string tag, input int qv, input int qbv, input bit en, input bit c);
        drive(qv, qbv, en, c);
        @(posedge clk);
        model_step(qv, qbv, en, c);
        #1;
        check_all(tag);
    endtask

    task automatic step(input string tag, input int qv);
        step_qb(tag, qv, 15 - qv, 1'b1, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cv, qv, qbv;
        bit en, c;
        rst_n = 1'b0;
        drive(0, 15, 1'b0, 1'b0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Free-run lock: locked right after the sample of 2.
        step("lock0", 0);
        step("lock1", 1);
        step("lock2", 2);
        chk("lock_after_2", 32'(bus_a.locked), 32'd1);
        step("lock3", 3);

        // Wrap while locked.
        for (int v = 4; v <= 15; v++) step("run", v);
        step("wrap0", 0);
        chk("wrap_cnt_is_1", 32'(bus_a.wrap_cnt), 32'd1);
        step("wrap1", 1);

        // Skip error at 5 -> 7, then relock on 8, 9.
        for (int v = 2; v <= 5; v++) step("run", v);
        step("skip7", 7);
        chk("skip_pulse", 32'(bus_a.err_pulse), 32'd1);
        step("resync8", 8);
        chk("pulse_one_cycle", 32'(bus_a.err_pulse), 32'd0);
        step("resync9", 9);
        chk("relocked", 32'(bus_a.locked), 32'd1);

        // qbar fault with correct q.
        step_qb("qbar_fault", 10, 4'b1000, 1'b1, 1'b0);
        chk("qbar_unlocked", 32'(bus_a.locked), 32'd0);
        step("re11", 11);
        step("re12", 12);

        // Hold with sample_en low, then error coinciding with clr.
        for (int i = 0; i < 3; i++) step_qb("hold", 12, 3, 1'b0, 1'b0);
        step_qb("err_clr", 5, 10, 1'b1, 1'b1);
        chk("err_clr_pulse", 32'(bus_a.err_pulse), 32'd1);
        chk("err_clr_cnt",   32'(bus_a.err_cnt),   32'd0);

        // Build up errors beyond the CNT_W=2 saturation point, then reset.
        cv = 5;
        for (int k = 0; k < 5; k++) begin
            step("re", (cv + 1) % 16);
            step("re", (cv + 2) % 16);
            cv = (cv + 2) % 16;
            step("bad", (cv + 3) % 16);
            cv = (cv + 3) % 16;
        end
        chk("sat_b", 32'(bus_b.err_cnt), 32'd3);
        async_reset("mid_reset");
        step("rl0", 3);
        step("rl1", 4);
        chk("not_yet", 32'(bus_a.locked), 32'd0);
        step("rl2", 5);

        // Randomized traffic.
        cv = 5;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom % 4) != 0;
            c   = ($urandom % 20) == 0;
            qv  = cv;
            qbv = 15 - cv;
            if (en) begin
                qv = (cv + 1) % 16;
                case ($urandom % 12)
                    0: qv = $urandom % 16;
                    1: qbv = (15 - qv) ^ (1 << ($urandom % 4));
                    default: ;
                endcase
                if (qbv == 15 - cv) qbv = 15 - qv;
                cv = qv;
            end
            if (i == 200) async_reset("rand_reset");
            step_qb("rand", qv, qbv, en, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
